mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
- Parametrised N-channel, W-bit registered multiplexer with two modes.
- Manual mode: selects a channel from a select input.
- Auto-scan mode: a sequencer steps round-robin through the enabled channels. It dwells DWELL cycles on each channel, then emits one sample with a valid/ready handshake.
- Successor to the fixed 16:1 single-bit combinational mux. Feeds serialising/sampling logic downstream.

Parameters:
- NCH, 16, number of input channels (2..64).
- W, 1, data width per channel.
- DWELL, 4, settle cycles on a channel before sampling (>=1).
- CW (localparam), $clog2(NCH), channel index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel_in  in  CW  manual-mode channel select.
- ch_en  in  NCH  scan channel-enable mask; sampled at start.
- din  in  NCH*W  channel data, channel k at bits [k*W +: W].
- start  in  1  one-cycle pulse, begins one scan sweep.
- y_out  out  W  registered selected data.
- y_ch  out  CW  channel index of y_out.
- y_valid  out  1  y_out/y_ch valid.
- y_ready  in  1  downstream accept (scan mode only).
- busy  out  1  sweep in progress.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - y_out=0, y_ch=0, y_valid=0, busy=0.
  - State IDLE, dwell counter=0, mask register=0.
  - Reset applies mid-sweep, aborts the sweep with no further emit, and overrides all other inputs.
- Manual mode (mode=1'b0, state IDLE):
  - Latency 1: y_out <= din[sel_in], y_ch <= sel_in, y_valid <= 1 every cycle; y_ready ignored.
  - sel_in >= NCH (non-power-of-2 NCH): y_out <= 0, y_valid <= 0.
- Scan FSM states: IDLE, DWELL, EMIT.
  - IDLE:
    - start=1, mode=1, ch_en!=0: latch mask <= ch_en; ch <= lowest set bit; counter <= 0; busy <= 1; y_valid <= 0; go to DWELL.
    - start with ch_en==0: no effect; stay IDLE, busy=0, no emit.
    - While in IDLE with mode=1: y_valid=0.
  - DWELL:
    - counter increments each cycle.
    - When counter==DWELL-1: y_out <= din[ch], y_ch <= ch, y_valid <= 1, go to EMIT.
    - First emit therefore occurs DWELL cycles after the start edge.
  - EMIT:
    - Hold y_out/y_ch/y_valid stable while y_ready=0.
    - On y_valid&&y_ready: y_valid <= 0.
    - If a higher enabled channel exists in mask: ch <= next higher enabled index, counter <= 0, go to DWELL.
    - Otherwise (wrap point): busy <= 0, go to IDLE. One sweep = one sample per enabled channel, in ascending order.
- Mid-sweep input changes:
  - start during busy is ignored.
  - mode and ch_en changes during busy are ignored until IDLE, because the mask is latched.
  - Manual mode resumes only in IDLE.
- Single-channel mask: exactly one emit per start.
- Highest-channel wrap: the EMIT accept on the last enabled channel ends the sweep; no restart at channel 0.

Decomposition:
- Shared package mux_pkg:
  - State enum (IDLE, DWELL, EMIT).
  - Mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
  - Channel-index width function.
- One sub-module, rr_next_sel:
  - Combinational. Inputs: mask and current index.
  - Outputs: next higher set index and a found flag; also the lowest set index for the first selection.
- mux_scan_seq contains the FSM, counter, and output registers.

Test Plan:
- Manual, NCH=16, W=1: drive din=16'h8001, sel_in=0 then 15 then 5 -> y_out=1,1,0 one cycle after each change; y_valid=1; y_ch tracks sel_in.
- Scan, NCH=16, W=8, DWELL=4, ch_en=16'h0025, din[k]=k+8'h10, y_ready=1 -> emits (ch 0, 8'h10), (ch 2, 8'h12), (ch 5, 8'h15).
  - First y_valid is 4 cycles after start; each subsequent emit follows an accept by DWELL+1 cycles.
  - busy falls after the ch 5 accept.
- Backpressure: same setup, hold y_ready=0 for 10 cycles on ch 2 -> y_out=8'h12, y_ch=2, y_valid=1 stable all 10 cycles; ch 5 dwell starts only after accept.
- Empty/ignored start: start with ch_en=0 -> busy stays 0, y_valid stays 0. Start pulse while busy, and ch_en change mid-sweep -> emitted sequence unchanged.
- Reset mid-sweep: assert rst_n=0 for one edge while in DWELL on ch 2 -> next cycle y_valid=0, busy=0, y_out=0, y_ch=0. A new start restarts from the lowest enabled channel.
- Non-power-of-2, NCH=12: manual sel_in=13 -> y_out=0, y_valid=0. Scan ch_en=12'h800 -> single emit on ch 11, then IDLE.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning channel multiplexer.
// FSM state encoding, mode constants and the index-width helper.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin helper: next enabled index above i_cur plus lowest enabled index.
// Purely combinational, zero latency; no handshake of its own.
module rr_next_sel
    import mux_pkg::*;
#(
    parameter int NCH = 16,
    parameter int CW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] i_mask,
    input  logic [CW-1:0]  i_cur,
    output logic [CW-1:0]  o_nxt,
    output logic           o_found,
    output logic [CW-1:0]  o_low
);

    // Scanning downwards lets the last hit win, which is the lowest match.
    always_comb begin
        o_nxt   = '0;
        o_found = 1'b0;
        o_low   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_low = CW'(i);
                if (i > int'(i_cur)) begin
                    o_nxt   = CW'(i);
                    o_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// N-channel registered mux: manual select (latency 1) or auto-scan sweep (DWELL cycles per channel).
// Scan samples hold on y_out/y_ch/y_valid until y_ready; manual mode ignores y_ready.
module mux_scan_seq
    import mux_pkg::*;
#(
    parameter int NCH   = 16,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int CW   = idx_w(NCH),
    localparam int DCW  = idx_w(DWELL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [CW-1:0]    sel_in,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH*W-1:0] din,
    input  logic             start,
    output logic [W-1:0]     y_out,
    output logic [CW-1:0]    y_ch,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy
);

    state_t           r_state;
    logic [DCW-1:0]   r_cnt;
    logic [NCH-1:0]   r_mask;
    logic [CW-1:0]    r_ch;
    logic [W-1:0]     r_y_out;
    logic [CW-1:0]    r_y_ch;
    logic             r_y_valid;
    logic             r_busy;

    logic [W-1:0]     w_sel_dat;
    logic             w_sel_ok;
    logic [W-1:0]     w_ch_dat;
    logic [NCH-1:0]   w_mask;
    logic [CW-1:0]    w_nxt;
    logic             w_found;
    logic [CW-1:0]    w_low;

    // Out-of-range selects (non-power-of-2 NCH) match no channel and leave w_sel_ok low.
    always_comb begin
        w_sel_dat = '0;
        w_sel_ok  = 1'b0;
        w_ch_dat  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (CW'(k) == sel_in) begin
                w_sel_dat = din[k*W +: W];
                w_sel_ok  = 1'b1;
            end
            if (CW'(k) == r_ch) begin
                w_ch_dat = din[k*W +: W];
            end
        end
    end

    // IDLE looks at the live enable mask to pick the first channel; a sweep uses the latched one.
    assign w_mask = (r_state == ST_IDLE) ? ch_en : r_mask;

    rr_next_sel #(.NCH(NCH), .CW(CW)) u_rr_next_sel (
        .i_mask  (w_mask),
        .i_cur   (r_ch),
        .o_nxt   (w_nxt),
        .o_found (w_found),
        .o_low   (w_low)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_ch      <= '0;
            r_y_out   <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mode == MODE_MANUAL) begin
                        r_y_ch    <= sel_in;
                        r_y_out   <= w_sel_ok ? w_sel_dat : '0;
                        r_y_valid <= w_sel_ok;
                    end else begin
                        r_y_valid <= 1'b0;
                        if (start && (|ch_en)) begin
                            r_mask  <= ch_en;
                            r_ch    <= w_low;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_DWELL;
                        end
                    end
                end
                ST_DWELL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == DCW'(DWELL - 1)) begin
                        r_y_out   <= w_ch_dat;
                        r_y_ch    <= r_ch;
                        r_y_valid <= 1'b1;
                        r_state   <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // y_valid is always high here, so y_ready alone completes the handshake.
                    if (y_ready) begin
                        r_y_valid <= 1'b0;
                        if (w_found) begin
                            r_ch    <= w_nxt;
                            r_cnt   <= '0;
                            r_state <= ST_DWELL;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign y_out   = r_y_out;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: manual select, scan sweeps, backpressure, reset and non-power-of-2 channels.
module tb_mux_scan_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // A: NCH=16, W=1, manual only
    logic [3:0]  a_sel = '0;
    logic [15:0] a_din = '0;
    logic        a_y_out;
    logic [3:0]  a_y_ch;
    logic        a_y_valid;
    logic        a_busy;

    // B: NCH=16, W=8, DWELL=4, scan
    logic         b_mode = 1'b1;
    logic [3:0]   b_sel = '0;
    logic [15:0]  b_ch_en = '0;
    logic [127:0] b_din = '0;
    logic         b_start = 1'b0;
    logic         b_ready = 1'b0;
    logic [7:0]   b_y_out;
    logic [3:0]   b_y_ch;
    logic         b_y_valid;
    logic         b_busy;

    // C: NCH=12, W=8, DWELL=4
    logic         c_mode = 1'b1;
    logic [3:0]   c_sel = '0;
    logic [11:0]  c_ch_en = '0;
    logic [95:0]  c_din = '0;
    logic         c_start = 1'b0;
    logic         c_ready = 1'b1;
    logic [7:0]   c_y_out;
    logic [3:0]   c_y_ch;
    logic         c_y_valid;
    logic         c_busy;

    mux_scan_seq #(.NCH(16), .W(1), .DWELL(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel_in(a_sel), .ch_en(16'h0000),
        .din(a_din), .start(1'b0), .y_out(a_y_out), .y_ch(a_y_ch),
        .y_valid(a_y_valid), .y_ready(1'b0), .busy(a_busy)
    );

    mux_scan_seq #(.NCH(16), .W(8), .DWELL(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel_in(b_sel), .ch_en(b_ch_en),
        .din(b_din), .start(b_start), .y_out(b_y_out), .y_ch(b_y_ch),
        .y_valid(b_y_valid), .y_ready(b_ready), .busy(b_busy)
    );

    mux_scan_seq #(.NCH(12), .W(8), .DWELL(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .mode(c_mode), .sel_in(c_sel), .ch_en(c_ch_en),
        .din(c_din), .start(c_start), .y_out(c_y_out), .y_ch(c_y_ch),
        .y_valid(c_y_valid), .y_ready(c_ready), .busy(c_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until B shows y_valid; the count includes any accept edge taken inside the loop.
    task automatic b_expect(input string tag, input int exp_ch, input logic [7:0] exp_dat, input int exp_lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!b_y_valid && n < 60);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_ch"},  b_y_ch, exp_ch);
        chk({tag, "_dat"}, b_y_out, exp_dat);
    endtask

    task automatic b_start_pulse();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) b_din[k*8 +: 8] = 8'(16 + k);
        for (int k = 0; k < 12; k++) c_din[k*8 +: 8] = 8'(160 + k);

        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_y_out",   b_y_out, 0);
        chk("rst_y_ch",    b_y_ch, 0);
        chk("rst_y_valid", b_y_valid, 0);
        chk("rst_busy",    b_busy, 0);

        // Manual mode, one cycle per select change
        a_din = 16'h8001;
        a_sel = 4'd0;  tick();
        chk("man0_out", a_y_out, 1); chk("man0_ch", a_y_ch, 0);  chk("man0_vld", a_y_valid, 1);
        a_sel = 4'd15; tick();
        chk("man15_out", a_y_out, 1); chk("man15_ch", a_y_ch, 15); chk("man15_vld", a_y_valid, 1);
        a_sel = 4'd5;  tick();
        chk("man5_out", a_y_out, 0); chk("man5_ch", a_y_ch, 5);  chk("man5_vld", a_y_valid, 1);

        // Plain sweep over channels 0, 2, 5
        b_ch_en = 16'h0025;
        b_ready = 1'b1;
        b_start_pulse();
        chk("sw_busy", b_busy, 1);
        b_expect("sw_c0", 0, 8'h10, 4);
        b_expect("sw_c2", 2, 8'h12, 5);
        b_expect("sw_c5", 5, 8'h15, 5);
        tick();
        chk("sw_end_busy", b_busy, 0);
        chk("sw_end_vld",  b_y_valid, 0);

        // Backpressure on channel 2
        b_start_pulse();
        b_expect("bp_c0", 0, 8'h10, 4);
        b_expect("bp_c2", 2, 8'h12, 5);
        b_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", {b_y_valid, b_y_ch, b_y_out}, {1'b1, 4'd2, 8'h12});
        end
        b_ready = 1'b1;
        b_expect("bp_c5", 5, 8'h15, 5);
        tick();
        chk("bp_end_busy", b_busy, 0);

        // Start with an empty mask does nothing
        b_ch_en = 16'h0000;
        b_start_pulse();
        tick();
        chk("empty_busy", b_busy, 0);
        chk("empty_vld",  b_y_valid, 0);

        // Start pulse and mask change mid-sweep are ignored
        b_ch_en = 16'h0025;
        b_start_pulse();
        b_expect("ign_c0", 0, 8'h10, 4);
        b_start = 1'b1;
        b_ch_en = 16'h0100;
        tick();
        b_start = 1'b0;
        b_expect("ign_c2", 2, 8'h12, 4);
        b_expect("ign_c5", 5, 8'h15, 5);
        tick();
        chk("ign_end_busy", b_busy, 0);

        // Reset while dwelling on channel 2, then restart
        b_ch_en = 16'h0025;
        b_start_pulse();
        b_expect("rs_c0", 0, 8'h10, 4);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs_vld",  b_y_valid, 0);
        chk("rs_busy", b_busy, 0);
        chk("rs_out",  b_y_out, 0);
        chk("rs_ch",   b_y_ch, 0);
        b_start_pulse();
        b_expect("rs2_c0", 0, 8'h10, 4);
        b_expect("rs2_c2", 2, 8'h12, 5);
        b_expect("rs2_c5", 5, 8'h15, 5);
        tick();
        chk("rs2_end_busy", b_busy, 0);

        // Twelve channels: out-of-range select, then single-channel sweep on the top channel
        c_mode = 1'b0;
        c_sel  = 4'd13;
        tick();
        chk("c_oor_out", c_y_out, 0);
        chk("c_oor_vld", c_y_valid, 0);
        c_sel = 4'd11;
        tick();
        chk("c_man11_out", c_y_out, 8'hAB);
        chk("c_man11_vld", c_y_valid, 1);
        c_mode  = 1'b1;
        c_ch_en = 12'h800;
        tick();
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!c_y_valid && n < 60);
            chk("c_scan_lat", n, 4);
            chk("c_scan_ch",  c_y_ch, 11);
            chk("c_scan_dat", c_y_out, 8'hAB);
        end
        tick();
        chk("c_end_busy", c_busy, 0);
        chk("c_end_vld",  c_y_valid, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("c_no_restart_vld",  c_y_valid, 0);
        chk("c_no_restart_busy", c_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
